// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - field limits, widths and types shared by the watch datapath
package watch_pkg;

  localparam int unsigned MSEC_MAX = 99;
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  typedef logic [MSEC_W-1:0] msec_t;
  typedef logic [SEC_W-1:0]  sec_t;
  typedef logic [MIN_W-1:0]  min_t;
  typedef logic [HOUR_W-1:0] hour_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider, one-cycle o_tick every FCOUNT clk cycles
module tick_gen #(
  parameter int FCOUNT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int CW = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(FCOUNT - 1);

  logic [CW-1:0] cnt;

  assign o_tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/watch_dp.sv
// rtl/watch_dp.sv - hh:mm:ss.cc counter chain with manual adjust ticks
// WATCH_ADJ_CARRY_EN: when defined, manual-tick wraps of sec/min carry onward.
module watch_dp
  import watch_pkg::*;
#(
  parameter int FCOUNT    = 1_000_000,
  parameter int INIT_HOUR = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_sec,
  input  logic              tick_min,
  input  logic              tick_hour,
  output logic [MSEC_W-1:0] msec,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour
);

  localparam msec_t MSEC_TOP  = msec_t'(MSEC_MAX);
  localparam sec_t  SEC_TOP   = sec_t'(SEC_MAX);
  localparam min_t  MIN_TOP   = min_t'(MIN_MAX);
  localparam hour_t HOUR_TOP  = hour_t'(HOUR_MAX);
  localparam hour_t HOUR_INIT = hour_t'(INIT_HOUR);

  logic tick_100hz;
  logic c_msec;
  logic sec_en, sec_wrap, c_sec;
  logic min_en, min_wrap, c_min;
  logic hour_en, hour_wrap;

  tick_gen #(
    .FCOUNT(FCOUNT)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .o_tick(tick_100hz)
  );

  // >= rather than == so a field can never sit outside its range
  assign c_msec    = tick_100hz && (msec >= MSEC_TOP);
  assign sec_en    = c_msec || tick_sec;
  assign sec_wrap  = sec_en && (sec >= SEC_TOP);
  assign min_en    = c_sec || tick_min;
  assign min_wrap  = min_en && (min >= MIN_TOP);
  assign hour_en   = c_min || tick_hour;
  assign hour_wrap = hour_en && (hour >= HOUR_TOP);

`ifdef WATCH_ADJ_CARRY_EN
  assign c_sec = sec_wrap;
  assign c_min = min_wrap;
`else
  // only a wrap driven by the lower field's carry propagates upward
  assign c_sec = sec_wrap && c_msec;
  assign c_min = min_wrap && c_sec;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      msec <= '0;
      sec  <= '0;
      min  <= '0;
      hour <= HOUR_INIT;
    end else begin
      if (tick_100hz) msec <= c_msec ? '0 : msec + msec_t'(1);
      if (sec_en)     sec  <= sec_wrap ? '0 : sec + sec_t'(1);
      if (min_en)     min  <= min_wrap ? '0 : min + min_t'(1);
      if (hour_en)    hour <= hour_wrap ? '0 : hour + hour_t'(1);
    end
  end

endmodule

// File: tb/tb_watch_dp.sv
// tb/tb_watch_dp.sv - directed self-checking bench for watch_dp (FCOUNT=10, INIT_HOUR=12)
// Honours WATCH_ADJ_CARRY_EN for the manual-wrap expectation.
module tb_watch_dp;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_sec = 1'b0;
  logic       tick_min = 1'b0;
  logic       tick_hour = 1'b0;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;

  int passed = 0;
  int total  = 0;
  int cyc_cnt = 0;

`ifdef WATCH_ADJ_CARRY_EN
  localparam logic [5:0] WRAP_MIN = 6'd1;
`else
  localparam logic [5:0] WRAP_MIN = 6'd0;
`endif

  watch_dp #(
    .FCOUNT(10),
    .INIT_HOUR(12)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_sec (tick_sec),
    .tick_min (tick_min),
    .tick_hour(tick_hour),
    .msec     (msec),
    .sec      (sec),
    .min      (min),
    .hour     (hour)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick_sec = 1'b0; tick_min = 1'b0; tick_hour = 1'b0;
    cyc();
    reset = 1'b0;
    cyc_cnt = 0;
  endtask

  task automatic manual(input int ns, input int nm, input int nh);
    int n;
    n = (ns > nm) ? ns : nm;
    n = (nh > n) ? nh : n;
    for (int k = 0; k < n; k++) begin
      tick_sec  = (k < ns);
      tick_min  = (k < nm);
      tick_hour = (k < nh);
      cyc();
    end
    tick_sec = 1'b0; tick_min = 1'b0; tick_hour = 1'b0;
  endtask

  task automatic run_to(input int t);
    while (cyc_cnt < t) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick_sec = 1'b1; tick_min = 1'b1; tick_hour = 1'b1;
    cyc();
    cyc();
    total++; if (msec !== 7'd0) $display("FAIL reset_msec: got %0d want 0", msec); else passed++;
    total++; if (sec !== 6'd0) $display("FAIL reset_sec: got %0d want 0", sec); else passed++;
    total++; if (min !== 6'd0) $display("FAIL reset_min: got %0d want 0", min); else passed++;
    total++; if (hour !== 5'd12) $display("FAIL reset_hour: got %0d want 12", hour); else passed++;
    tick_sec = 1'b0; tick_min = 1'b0; tick_hour = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_run();
    do_reset();
    run_to(9);
    total++; if (msec !== 7'd0) $display("FAIL run_msec_9: got %0d want 0", msec); else passed++;
    run_to(10);
    total++; if (msec !== 7'd1) $display("FAIL run_msec_10: got %0d want 1", msec); else passed++;
    run_to(100);
    total++; if (msec !== 7'd10) $display("FAIL run_msec_100: got %0d want 10", msec); else passed++;
    total++; if (sec !== 6'd0) $display("FAIL run_sec_100: got %0d want 0", sec); else passed++;
    run_to(1000);
    total++; if (sec !== 6'd1) $display("FAIL run_sec_1000: got %0d want 1", sec); else passed++;
    total++; if (msec !== 7'd0) $display("FAIL run_msec_1000: got %0d want 0", msec); else passed++;
    total++; if (min !== 6'd0) $display("FAIL run_min_1000: got %0d want 0", min); else passed++;
  endtask

  task automatic test_rollover();
    do_reset();
    manual(59, 59, 11);
    run_to(999);
    total++; if (hour !== 5'd23) $display("FAIL roll_pre_hour: got %0d want 23", hour); else passed++;
    total++; if (min !== 6'd59) $display("FAIL roll_pre_min: got %0d want 59", min); else passed++;
    total++; if (sec !== 6'd59) $display("FAIL roll_pre_sec: got %0d want 59", sec); else passed++;
    total++; if (msec !== 7'd99) $display("FAIL roll_pre_msec: got %0d want 99", msec); else passed++;
    cyc();
    total++; if (hour !== 5'd0) $display("FAIL roll_hour: got %0d want 0", hour); else passed++;
    total++; if (min !== 6'd0) $display("FAIL roll_min: got %0d want 0", min); else passed++;
    total++; if (sec !== 6'd0) $display("FAIL roll_sec: got %0d want 0", sec); else passed++;
    total++; if (msec !== 7'd0) $display("FAIL roll_msec: got %0d want 0", msec); else passed++;
  endtask

  task automatic test_manual_wrap();
    do_reset();
    manual(59, 0, 0);
    total++; if (sec !== 6'd59) $display("FAIL mwrap_pre_sec: got %0d want 59", sec); else passed++;
    manual(1, 0, 0);
    total++; if (sec !== 6'd0) $display("FAIL mwrap_sec: got %0d want 0", sec); else passed++;
    total++; if (min !== WRAP_MIN) $display("FAIL mwrap_min: got %0d want %0d", min, WRAP_MIN); else passed++;
    total++; if (msec !== 7'd6) $display("FAIL mwrap_msec: got %0d want 6", msec); else passed++;
  endtask

  task automatic test_coincident();
    do_reset();
    manual(10, 0, 0);
    run_to(999);
    total++; if (sec !== 6'd10) $display("FAIL coin_pre_sec: got %0d want 10", sec); else passed++;
    tick_sec = 1'b1;
    cyc();
    tick_sec = 1'b0;
    total++; if (sec !== 6'd11) $display("FAIL coin_sec: got %0d want 11", sec); else passed++;
    total++; if (msec !== 7'd0) $display("FAIL coin_msec: got %0d want 0", msec); else passed++;
    // both sources at sec=59: carry must reach min in either build
    do_reset();
    manual(59, 0, 0);
    run_to(999);
    tick_sec = 1'b1;
    cyc();
    tick_sec = 1'b0;
    total++; if (sec !== 6'd0) $display("FAIL both_sec: got %0d want 0", sec); else passed++;
    total++; if (min !== 6'd1) $display("FAIL both_min: got %0d want 1", min); else passed++;
  endtask

  task automatic test_hold_hour();
    do_reset();
    manual(0, 0, 13);
    total++; if (hour !== 5'd1) $display("FAIL hold_hour: got %0d want 1", hour); else passed++;
    total++; if (msec !== 7'd1) $display("FAIL hold_msec_13: got %0d want 1", msec); else passed++;
    run_to(20);
    total++; if (msec !== 7'd2) $display("FAIL hold_msec_20: got %0d want 2", msec); else passed++;
    total++; if (min !== 6'd0) $display("FAIL hold_min: got %0d want 0", min); else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    manual(20, 30, 17);
    run_to(507);
    total++; if (hour !== 5'd5) $display("FAIL mid_pre_hour: got %0d want 5", hour); else passed++;
    total++; if (min !== 6'd30) $display("FAIL mid_pre_min: got %0d want 30", min); else passed++;
    total++; if (sec !== 6'd20) $display("FAIL mid_pre_sec: got %0d want 20", sec); else passed++;
    total++; if (msec !== 7'd50) $display("FAIL mid_pre_msec: got %0d want 50", msec); else passed++;
    do_reset();
    total++; if (hour !== 5'd12) $display("FAIL mid_hour: got %0d want 12", hour); else passed++;
    total++; if (min !== 6'd0) $display("FAIL mid_min: got %0d want 0", min); else passed++;
    total++; if (sec !== 6'd0) $display("FAIL mid_sec: got %0d want 0", sec); else passed++;
    total++; if (msec !== 7'd0) $display("FAIL mid_msec: got %0d want 0", msec); else passed++;
    run_to(9);
    total++; if (msec !== 7'd0) $display("FAIL mid_msec_9: got %0d want 0", msec); else passed++;
    run_to(10);
    total++; if (msec !== 7'd1) $display("FAIL mid_msec_10: got %0d want 1", msec); else passed++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_rollover();
    test_manual_wrap();
    test_coincident();
    test_hold_hour();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/watch_dp.md
WATCH_DP -- requirements
Module: watch_dp

Interface
- REQ-001 Parameter FCOUNT, default 1_000_000: clk cycles per 1/100 s tick (100 MHz clk to 100 Hz).
- REQ-002 Parameter INIT_HOUR, default 12: hour value loaded on reset, legal range 0..23.
- REQ-003 clk  input  1  system clock; all logic is on its rising edge.
- REQ-004 reset  input  1  synchronous, active-high reset.
- REQ-005 tick_sec  input  1  manual-adjust pulse; each high cycle adds one increment to sec.
- REQ-006 tick_min  input  1  manual-adjust pulse; each high cycle adds one increment to min.
- REQ-007 tick_hour  input  1  manual-adjust pulse; each high cycle adds one increment to hour.
- REQ-008 msec  output  7  centiseconds, 0..99, registered.
- REQ-009 sec  output  6  seconds, 0..59, registered.
- REQ-010 min  output  6  minutes, 0..59, registered.
- REQ-011 hour  output  5  hours, 0..23, registered.

Function
- REQ-012 The internal divider counts 0..FCOUNT-1 and shall assert tick_100hz for exactly one cycle when the count equals FCOUNT-1, then wrap to 0.
- REQ-013 msec shall increment on tick_100hz and wrap 99->0; wrap asserts carry c_msec in the same cycle.
- REQ-014 The sec increment enable is c_msec OR tick_sec: one increment per cycle even when both are high; wrap 59->0.
- REQ-015 The min increment enable is c_sec OR tick_min: one increment per cycle; wrap 59->0.
- REQ-016 The hour increment enable is c_min OR tick_hour: one increment per cycle; wrap 23->0; no carry out.
- REQ-017 Carries ripple combinationally within one cycle: at 23:59:59.99, a single tick_100hz yields 00:00:00.00 on the next edge.
- REQ-018 Latency: any increment is visible on outputs one clk edge after its enable is sampled high.
- REQ-019 A tick input held high for N cycles shall produce N increments (no edge detection in this block).
- REQ-020 Manual ticks shall not reset or stall the divider or msec.
- REQ-021 Outputs never take values outside their stated ranges.

Reset
- REQ-022 While reset is high at a clk edge: divider=0, msec=0, sec=0, min=0, hour=INIT_HOUR; tick inputs are ignored.
- REQ-023 A reset asserted mid-count shall discard any partial divider count; the first tick_100hz occurs FCOUNT cycles after reset deasserts.

Configuration
- REQ-024 Macro WATCH_ADJ_CARRY_EN selects carry behaviour on manual wrap.
- REQ-025 With WATCH_ADJ_CARRY_EN defined, a wrap caused by tick_sec or tick_min also carries into the next field.
- REQ-026 Without WATCH_ADJ_CARRY_EN, a wrap caused only by a manual tick does not carry. Only c_msec/auto-driven wraps carry, and a wrap with both sources high still carries.

Structure
- REQ-027 Shared package watch_pkg holds MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23 and the output field widths.
- REQ-028 Divider is sub-module tick_gen (params FCOUNT; ports clk, reset, o_tick); the counter chain and carry logic stay in watch_dp.

Verification
Bench parameters: FCOUNT=10, INIT_HOUR=12.
- REQ-029 Reset, then run 100 cycles -> msec=10 and sec=0; after 1000 cycles -> sec=1 and msec=0.
- REQ-030 Force 23:59:59.99 via manual ticks plus run, then issue one tick_100hz -> 00:00:00.00 next edge.
- REQ-031 At sec=59, pulse tick_sec one cycle -> sec=0. Min increments iff WATCH_ADJ_CARRY_EN; run both builds.
- REQ-032 Align tick_sec high in the same cycle as a c_msec with sec=10 -> sec=11, not 12.
- REQ-033 Hold tick_hour high 13 cycles from hour=12 -> hour=1; msec keeps counting undisturbed.
- REQ-034 Assert reset for 1 cycle at divider count 7 with the clock at 05:30:20.50 -> outputs 12:00:00.00; the first msec increment follows 10 cycles after deassertion.
